// File: rtl/axil_cmd_master.sv
// ---------------------------------------------------------------------------
// axil_cmd_master
//
// AXI4-Lite initiator driven by single-word fabric commands. Each accepted
// command becomes one AXI4-Lite write, one read, or a poll (a sequence of
// reads until a masked compare matches, the slave errors, or POLL_MAX reads
// have been made). One command is in flight at a time. The result is held on
// the rsp_* interface until rsp_ready.
//
// Ports
//   axi_aclk, axi_aresetn     clock, asynchronous active-low reset
//   cmd_valid/cmd_ready       command handshake
//   cmd_op                    00 write, 01 read, 10 poll, 11 illegal
//   cmd_addr                  byte address (ADDR_W)
//   cmd_wdata                 write data / poll compare value
//   cmd_wstrb                 write strobes
//   cmd_mask                  poll compare mask
//   rsp_valid/rsp_ready       response handshake
//   rsp_rdata/rsp_resp        read data (0 for write) and AXI response code
//   rsp_timeout               poll ran out of attempts
//   M_AXI_*                   AXI4-Lite master channels AW, W, B, AR, R
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module axil_cmd_master #(
  parameter int unsigned ADDR_W   = 40,
  parameter int unsigned POLL_MAX = 1024,
  parameter int unsigned POLL_GAP = 16
) (
  input  logic              axi_aclk,
  input  logic              axi_aresetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  input  logic [3:0]        cmd_wstrb,
  input  logic [31:0]       cmd_mask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] M_AXI_awaddr,
  output logic [2:0]        M_AXI_awprot,
  output logic              M_AXI_awvalid,
  input  logic              M_AXI_awready,
  output logic [31:0]       M_AXI_wdata,
  output logic [3:0]        M_AXI_wstrb,
  output logic              M_AXI_wvalid,
  input  logic              M_AXI_wready,
  input  logic [1:0]        M_AXI_bresp,
  input  logic              M_AXI_bvalid,
  output logic              M_AXI_bready,
  output logic [ADDR_W-1:0] M_AXI_araddr,
  output logic [2:0]        M_AXI_arprot,
  output logic              M_AXI_arvalid,
  input  logic              M_AXI_arready,
  input  logic [31:0]       M_AXI_rdata,
  input  logic [1:0]        M_AXI_rresp,
  input  logic              M_AXI_rvalid,
  output logic              M_AXI_rready
);

  localparam int unsigned CNT_W = $clog2(POLL_MAX + 1);
  localparam int unsigned GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(POLL_MAX);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((POLL_GAP > 0) ? (POLL_GAP - 1) : 0);

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_POLL  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WADDR = 3'd1,
    S_WRESP = 3'd2,
    S_RADDR = 3'd3,
    S_RDATA = 3'd4,
    S_GAP   = 3'd5,
    S_RSP   = 3'd6
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;       // write data, or poll compare value
  logic [3:0]        wstrb_q, wstrb_d;
  logic [31:0]       mask_q, mask_d;
  logic [CNT_W-1:0]  attempts_q, attempts_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              bready_q, bready_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic [1:0]        rsp_resp_q, rsp_resp_d;
  logic              rsp_timeout_q, rsp_timeout_d;

  // Next-state and next-output logic; every output flop gets its next value here.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    mask_d        = mask_q;
    attempts_d    = attempts_q;
    gap_d         = gap_q;
    cmd_ready_d   = cmd_ready_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    bready_d      = bready_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_timeout_d = rsp_timeout_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d        = cmd_op;
          addr_d      = cmd_addr;
          wdata_d     = cmd_wdata;
          wstrb_d     = cmd_wstrb;
          mask_d      = cmd_mask;
          attempts_d  = {CNT_W{1'b0}};
          cmd_ready_d = 1'b0;
          case (cmd_op)
            OP_WRITE: begin
              state_d   = S_WADDR;
              awvalid_d = 1'b1;
              wvalid_d  = 1'b1;
            end
            OP_READ, OP_POLL: begin
              state_d   = S_RADDR;
              arvalid_d = 1'b1;
            end
            default: begin
              // Illegal opcode: answer SLVERR without touching the bus.
              state_d       = S_RSP;
              rsp_valid_d   = 1'b1;
              rsp_rdata_d   = 32'd0;
              rsp_resp_d    = 2'b10;
              rsp_timeout_d = 1'b0;
            end
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end

      S_WADDR: begin
        // AW and W retire independently; a channel already done stays low.
        awvalid_d = awvalid_q & ~M_AXI_awready;
        wvalid_d  = wvalid_q & ~M_AXI_wready;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = S_WRESP;
          bready_d = 1'b1;
        end else begin
          state_d = S_WADDR;
        end
      end

      S_WRESP: begin
        if (M_AXI_bvalid) begin
          state_d       = S_RSP;
          bready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = 32'd0;
          rsp_resp_d    = M_AXI_bresp;
          rsp_timeout_d = 1'b0;
        end else begin
          state_d = S_WRESP;
        end
      end

      S_RADDR: begin
        if (M_AXI_arready) begin
          state_d   = S_RDATA;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end else begin
          state_d = S_RADDR;
        end
      end

      S_RDATA: begin
        if (M_AXI_rvalid) begin
          rready_d      = 1'b0;
          rsp_rdata_d   = M_AXI_rdata;
          rsp_resp_d    = M_AXI_rresp;
          rsp_timeout_d = 1'b0;
          attempts_d    = attempts_q + {{(CNT_W-1){1'b0}}, 1'b1};
          if (op_q != OP_POLL) begin
            state_d     = S_RSP;
            rsp_valid_d = 1'b1;
          end else if (M_AXI_rresp != 2'b00) begin
            state_d     = S_RSP;
            rsp_valid_d = 1'b1;
          end else if (((M_AXI_rdata ^ wdata_q) & mask_q) == 32'd0) begin
            state_d     = S_RSP;
            rsp_valid_d = 1'b1;
          end else if (attempts_d == CNT_MAX) begin
            // Out of attempts; resp is already OKAY on this branch.
            state_d       = S_RSP;
            rsp_valid_d   = 1'b1;
            rsp_timeout_d = 1'b1;
          end else if (POLL_GAP == 32'd0) begin
            state_d   = S_RADDR;
            arvalid_d = 1'b1;
          end else begin
            state_d = S_GAP;
            gap_d   = {GAP_W{1'b0}};
          end
        end else begin
          state_d = S_RDATA;
        end
      end

      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d   = S_RADDR;
          arvalid_d = 1'b1;
        end else begin
          state_d = S_GAP;
          gap_d   = gap_q + {{(GAP_W-1){1'b0}}, 1'b1};
        end
      end

      S_RSP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end else begin
          state_d = S_RSP;
        end
      end

      default: begin
        state_d     = S_IDLE;
        cmd_ready_d = 1'b1;
        awvalid_d   = 1'b0;
        wvalid_d    = 1'b0;
        bready_d    = 1'b0;
        arvalid_d   = 1'b0;
        rready_d    = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State register and output flops; reset leaves only cmd_ready high.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_q       <= S_IDLE;
      op_q          <= 2'b00;
      addr_q        <= {ADDR_W{1'b0}};
      wdata_q       <= 32'd0;
      wstrb_q       <= 4'd0;
      mask_q        <= 32'd0;
      attempts_q    <= {CNT_W{1'b0}};
      gap_q         <= {GAP_W{1'b0}};
      cmd_ready_q   <= 1'b1;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= 32'd0;
      rsp_resp_q    <= 2'b00;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      mask_q        <= mask_d;
      attempts_q    <= attempts_d;
      gap_q         <= gap_d;
      cmd_ready_q   <= cmd_ready_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      bready_q      <= bready_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  // One address register feeds both AW and AR; only one channel is ever valid.
  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign rsp_timeout   = rsp_timeout_q;
  assign M_AXI_awaddr  = addr_q;
  assign M_AXI_awprot  = 3'b000;
  assign M_AXI_awvalid = awvalid_q;
  assign M_AXI_wdata   = wdata_q;
  assign M_AXI_wstrb   = wstrb_q;
  assign M_AXI_wvalid  = wvalid_q;
  assign M_AXI_bready  = bready_q;
  assign M_AXI_araddr  = addr_q;
  assign M_AXI_arprot  = 3'b000;
  assign M_AXI_arvalid = arvalid_q;
  assign M_AXI_rready  = rready_q;

endmodule

// File: tb/tb_axil_cmd_master.sv
// ---------------------------------------------------------------------------
// tb_axil_cmd_master
//
// Drives directed and random commands into axil_cmd_master, answers the AXI
// side with a small slave whose per-channel wait states are configurable,
// and compares every response against an operation-level model of what a
// write, read, poll or illegal command should return.
// ---------------------------------------------------------------------------
module tb_axil_cmd_master;

  localparam int AW   = 40;
  localparam int PMAX = 4;
  localparam int PGAP = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic [AW-1:0] cmd_addr = '0;
  logic [31:0]   cmd_wdata = 32'd0;
  logic [3:0]    cmd_wstrb = 4'd0;
  logic [31:0]   cmd_mask = 32'd0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [31:0]   rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          rsp_timeout;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic          awvalid, wvalid, bready, arvalid, rready;
  logic          awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [31:0]   wdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp = 2'b00, rresp = 2'b00;
  logic [31:0]   rdata = 32'd0;

  axil_cmd_master #(.ADDR_W(AW), .POLL_MAX(PMAX), .POLL_GAP(PGAP)) dut (
    .axi_aclk(clk), .axi_aresetn(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb), .cmd_mask(cmd_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .M_AXI_awaddr(awaddr), .M_AXI_awprot(awprot), .M_AXI_awvalid(awvalid), .M_AXI_awready(awready),
    .M_AXI_wdata(wdata), .M_AXI_wstrb(wstrb), .M_AXI_wvalid(wvalid), .M_AXI_wready(wready),
    .M_AXI_bresp(bresp), .M_AXI_bvalid(bvalid), .M_AXI_bready(bready),
    .M_AXI_araddr(araddr), .M_AXI_arprot(arprot), .M_AXI_arvalid(arvalid), .M_AXI_arready(arready),
    .M_AXI_rdata(rdata), .M_AXI_rresp(rresp), .M_AXI_rvalid(rvalid), .M_AXI_rready(rready)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int chk_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Slave configuration (written by the stimulus) and read-data script
  int          cfg_aw = 0, cfg_w = 0, cfg_b = 0, cfg_ar = 0, cfg_r = 0;
  logic [1:0]  cfg_bresp = 2'b00;
  logic [31:0] rq_data[$];
  logic [1:0]  rq_resp[$];
  int          cmd_seq = 0;

  // Slave-owned state and observation records
  int aw_wait, w_wait, b_wait, ar_wait, r_wait, rd_idx, seen_seq = 0;
  bit aw_seen, w_seen, b_armed, b_hs, r_armed, r_hs;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  int aw_cyc = 0, w_cyc = 0, b_cyc = 0, r_cyc = 0;
  int ar_cyc_q[$];
  logic [AW-1:0] aw_addr_s = '0, ar_addr_s = '0;
  logic [31:0]   w_data_s = 32'd0;
  logic [3:0]    w_strb_s = 4'd0;

  // AXI4-Lite slave: decides ready/valid on the falling edge; a handshake is
  // counted when both sides are high, i.e. it completes on the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
      arready = 1'b0; rvalid = 1'b0; rdata = 32'd0; rresp = 2'b00;
      aw_wait = cfg_aw; w_wait = cfg_w; ar_wait = cfg_ar; b_wait = 0; r_wait = 0;
      aw_seen = 0; w_seen = 0; b_armed = 0; b_hs = 0; r_armed = 0; r_hs = 0;
    end else begin
      if (seen_seq != cmd_seq) begin seen_seq = cmd_seq; rd_idx = 0; end
      // B channel
      if (b_hs) begin bvalid = 1'b0; b_hs = 0; end
      if (b_armed && !bvalid) begin
        if (b_wait == 0) begin bvalid = 1'b1; bresp = cfg_bresp; b_armed = 0; end
        else b_wait--;
      end
      if (bvalid && bready) begin b_cnt++; b_cyc = cyc; b_hs = 1; end
      // R channel
      if (r_hs) begin rvalid = 1'b0; r_hs = 0; end
      if (r_armed && !rvalid) begin
        if (r_wait == 0) begin
          rvalid = 1'b1;
          rdata  = (rd_idx < rq_data.size()) ? rq_data[rd_idx] : 32'd0;
          rresp  = (rd_idx < rq_resp.size()) ? rq_resp[rd_idx] : 2'b00;
          rd_idx++;
          r_armed = 0;
        end else r_wait--;
      end
      if (rvalid && rready) begin r_cnt++; r_cyc = cyc; r_hs = 1; end
      // AW channel
      if (!awvalid) begin awready = 1'b0; aw_wait = cfg_aw; end
      else if (aw_wait == 0) begin
        awready = 1'b1; aw_cnt++; aw_cyc = cyc; aw_addr_s = awaddr; aw_seen = 1;
      end else begin awready = 1'b0; aw_wait--; end
      // W channel
      if (!wvalid) begin wready = 1'b0; w_wait = cfg_w; end
      else if (w_wait == 0) begin
        wready = 1'b1; w_cnt++; w_cyc = cyc; w_data_s = wdata; w_strb_s = wstrb; w_seen = 1;
      end else begin wready = 1'b0; w_wait--; end
      if (aw_seen && w_seen) begin aw_seen = 0; w_seen = 0; b_armed = 1; b_wait = cfg_b; end
      // AR channel
      if (!arvalid) begin arready = 1'b0; ar_wait = cfg_ar; end
      else if (ar_wait == 0) begin
        arready = 1'b1; ar_cnt++; ar_cyc_q.push_back(cyc); ar_addr_s = araddr;
        r_armed = 1; r_wait = cfg_r;
      end else begin arready = 1'b0; ar_wait--; end
    end
  end

  function automatic logic [31:0] rd_at(input int i);
    return (i < rq_data.size()) ? rq_data[i] : 32'd0;
  endfunction

  function automatic logic [1:0] rr_at(input int i);
    return (i < rq_resp.size()) ? rq_resp[i] : 2'b00;
  endfunction

  // Reference: what the command must return and how many reads it must issue.
  function automatic void model(input logic [1:0] op, input logic [31:0] wd, input logic [31:0] mk,
                                input logic [1:0] br, output logic [31:0] ed, output logic [1:0] er,
                                output logic et, output int nrd);
    bit done;
    ed = 32'd0; er = 2'b00; et = 1'b0; nrd = 0; done = 0;
    case (op)
      2'b00: er = br;
      2'b01: begin nrd = 1; ed = rd_at(0); er = rr_at(0); end
      2'b10: begin
        for (int i = 0; i < PMAX; i++) begin
          if (!done) begin
            nrd = i + 1; ed = rd_at(i); er = rr_at(i);
            if (er != 2'b00 || (ed & mk) == (wd & mk)) done = 1;
          end
        end
        if (!done) begin et = 1'b1; er = 2'b00; end
      end
      default: er = 2'b10;
    endcase
  endfunction

  // Present one command, wait for the response, hold rsp_ready low for
  // 'hold' cycles (checking the response stays put), then raise rsp_ready.
  task automatic run_cmd(input logic [1:0] op, input logic [AW-1:0] addr, input logic [31:0] wd,
                         input logic [3:0] ws, input logic [31:0] mk, input int hold,
                         output logic [31:0] o_d, output logic [1:0] o_r, output logic o_t,
                         output int acc, output int rspc);
    int n;
    @(negedge clk);
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws; cmd_mask = mk;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    check("cmd_accept_bound", {63'd0, n < 50}, 64'd1);
    acc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_wdata = $urandom; cmd_mask = $urandom; cmd_wstrb = 4'($urandom);
    n = 0;
    while (!rsp_valid && n < 300) begin @(negedge clk); n++; end
    check("rsp_wait_bound", {63'd0, n < 300}, 64'd1);
    rspc = cyc; o_d = rsp_rdata; o_r = rsp_resp; o_t = rsp_timeout;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("rsp_hold", {29'd0, rsp_valid, rsp_resp, rsp_timeout, rsp_rdata}, {29'd0, 1'b1, o_r, o_t, o_d});
    end
    rsp_ready = 1'b1;
  endtask

  // Run a command and compare its response and bus activity with the model.
  task automatic exec(input string tag, input logic [1:0] op, input logic [AW-1:0] addr,
                      input logic [31:0] wd, input logic [3:0] ws, input logic [31:0] mk,
                      input int hold, output int acc, output int rspc);
    logic [31:0] gd, ed;
    logic [1:0]  gr, er;
    logic        gt, et;
    int nrd, aw0, w0, b0, ar0;
    aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt; ar0 = ar_cnt;
    cmd_seq++;
    run_cmd(op, addr, wd, ws, mk, hold, gd, gr, gt, acc, rspc);
    model(op, wd, mk, cfg_bresp, ed, er, et, nrd);
    check({tag, "_rdata"}, 64'(gd), 64'(ed));
    check({tag, "_resp"}, 64'(gr), 64'(er));
    check({tag, "_timeout"}, 64'(gt), 64'(et));
    check({tag, "_nreads"}, 64'(ar_cnt - ar0), 64'(nrd));
    check({tag, "_nwrites"}, 64'({aw_cnt - aw0, w_cnt - w0, b_cnt - b0}),
          (op == 2'b00) ? 64'({32'd1, 32'd1, 32'd1}) : 64'd0);
    if (op == 2'b00) check({tag, "_wbeat"}, {aw_addr_s[23:0], w_data_s, 4'd0, w_strb_s},
                           {addr[23:0], wd, 4'd0, ws});
    if (op == 2'b01 || op == 2'b10) check({tag, "_araddr"}, 64'(ar_addr_s), 64'(addr));
  endtask

  initial begin
    int acc, rspc, prev_rspc, base, len, r;
    logic [63:0] a64;
    logic [1:0]  op;
    logic [31:0] wd, mk;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_valids", 64'({rsp_valid, awvalid, wvalid, bready, arvalid, rready, rsp_timeout}), 64'd0);
    check("rst_addrs", {awaddr[31:0], araddr[31:0]}, 64'd0);
    check("rst_data", {rsp_rdata, wdata}, 64'd0);
    check("rst_misc", 64'({rsp_resp, awprot, arprot, wstrb}), 64'd0);
    rst_n = 1'b1;

    // Zero-wait write: AW/W in cycle 1, B in cycle 2, response in cycle 3
    exec("wr0", 2'b00, 40'h0, 32'h0000_0001, 4'hF, 32'd0, 0, acc, rspc);
    check("wr0_aw_cyc", 64'(aw_cyc - acc), 64'd1);
    check("wr0_w_cyc", 64'(w_cyc - acc), 64'd1);
    check("wr0_b_cyc", 64'(b_cyc - acc), 64'd2);
    check("wr0_rsp_cyc", 64'(rspc - acc), 64'd3);
    prev_rspc = rspc;

    // Back-to-back zero-wait read returning SLVERR data
    rq_data = '{32'hDEAD_BEEF}; rq_resp = '{2'b10};
    exec("rd0", 2'b01, 40'h8, 32'd0, 4'd0, 32'd0, 0, acc, rspc);
    check("b2b_accept", 64'(acc - prev_rspc), 64'd1);
    check("rd0_ar_cyc", 64'(ar_cyc_q[ar_cyc_q.size() - 1] - acc), 64'd1);
    check("rd0_r_cyc", 64'(r_cyc - acc), 64'd2);
    check("rd0_rsp_cyc", 64'(rspc - acc), 64'd3);

    // arvalid held through two wait states
    cfg_ar = 2;
    exec("rd1", 2'b01, 40'h8, 32'd0, 4'd0, 32'd0, 1, acc, rspc);
    check("rd1_ar_cyc", 64'(ar_cyc_q[ar_cyc_q.size() - 1] - acc), 64'd3);
    cfg_ar = 0;

    // Write with awready delayed 3 and wready delayed 1
    cfg_aw = 3; cfg_w = 1; cfg_bresp = 2'b01;
    exec("wr1", 2'b00, 40'h10, 32'hA5A5_0F0F, 4'h3, 32'd0, 2, acc, rspc);
    check("wr1_w_cyc", 64'(w_cyc - acc), 64'd2);
    check("wr1_aw_cyc", 64'(aw_cyc - acc), 64'd4);
    cfg_aw = 0; cfg_w = 0; cfg_bresp = 2'b00;

    // Poll: three misses then a match; reads spaced by gap + 2
    rq_data = '{32'h0, 32'h0, 32'h0, 32'h6}; rq_resp = '{2'b00, 2'b00, 2'b00, 2'b00};
    base = ar_cyc_q.size();
    exec("poll0", 2'b10, 40'h0, 32'h2, 4'd0, 32'h2, 0, acc, rspc);
    for (int k = 1; k < 4; k++)
      check("poll0_spacing", 64'(ar_cyc_q[base + k] - ar_cyc_q[base + k - 1]), 64'(PGAP + 2));

    // Poll that never matches: exactly PMAX reads and a timeout
    rq_data = {}; rq_resp = {};
    exec("poll1", 2'b10, 40'h4, 32'h1, 4'd0, 32'h1, 0, acc, rspc);

    // Poll stopped by a DECERR on the first read
    rq_data = '{32'h0}; rq_resp = '{2'b11};
    exec("poll2", 2'b10, 40'h4, 32'h1, 4'd0, 32'h1, 0, acc, rspc);

    // Illegal opcode: immediate SLVERR, no bus activity
    exec("ill0", 2'b11, 40'h20, 32'h1234, 4'hF, 32'hFFFF, 0, acc, rspc);
    check("ill0_rsp_cyc", 64'(rspc - acc), 64'd1);

    // Random commands with random slave wait states
    for (int t = 0; t < 40; t++) begin
      r = $urandom_range(0, 9);
      op = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      a64 = {$urandom, $urandom};
      wd = $urandom;
      mk = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      cfg_aw = $urandom_range(0, 3); cfg_w = $urandom_range(0, 3); cfg_b = $urandom_range(0, 3);
      cfg_ar = $urandom_range(0, 3); cfg_r = $urandom_range(0, 3);
      cfg_bresp = 2'($urandom);
      rq_data = {}; rq_resp = {};
      len = $urandom_range(1, PMAX + 1);
      for (int i = 0; i < len; i++) begin
        r = $urandom_range(0, 9);
        rq_data.push_back((r < 3) ? ((wd & mk) | ($urandom & ~mk)) : $urandom);
        rq_resp.push_back((r == 9) ? 2'($urandom_range(1, 3)) : 2'b00);
      end
      exec("rnd", op, a64[AW-1:0], wd, 4'($urandom), mk, $urandom_range(0, 2), acc, rspc);
    end

    // Reset while AW and W are stalled
    cfg_aw = 50; cfg_w = 50; cfg_b = 0; cfg_ar = 0; cfg_r = 0; cfg_bresp = 2'b00;
    @(negedge clk);
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_addr = 40'h30; cmd_wdata = 32'hFFFF_0000; cmd_wstrb = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("pre_rst_awvalid", 64'({awvalid, wvalid}), 64'd3);
    #2 rst_n = 1'b0;
    #1 check("rst_mid_valids", 64'({awvalid, wvalid, bready, arvalid, rready, rsp_valid}), 64'd0);
    check("rst_mid_cmd_ready", 64'(cmd_ready), 64'd1);
    cfg_aw = 0; cfg_w = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    rq_data = '{32'h1357_9BDF}; rq_resp = '{2'b00};
    exec("rd_after_rst", 2'b01, 40'h44, 32'd0, 4'd0, 32'd0, 0, acc, rspc);
    @(negedge clk);
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
